// File: rtl/tone_seq_pkg.sv
// Shared constants and types for the tone sequencer: FSM state encodings,
// default widths and the note-table entry layout.
package tone_seq_pkg;

    localparam int DEF_PHASE_PRECISION = 16;
    localparam int DEF_DEPTH_LOG2      = 4;
    localparam int DEF_DUR_W           = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_LOAD = 2'd1;
    localparam state_t S_PLAY = 2'd2;
    localparam state_t S_DONE = 2'd3;

    // One note-table word as stored: increment in the upper bits, duration below.
    typedef struct packed {
        logic [DEF_PHASE_PRECISION-1:0] inc;
        logic [DEF_DUR_W-1:0]           dur;
    } note_entry_t;

endpackage

// File: rtl/tone_seq_note_table.sv
// Note table RAM: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module tone_seq_note_table #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a table of (phase increment, duration) notes to a sine NCO.
// Define TONE_SEQ_LOOP_EN to let the loop input restart the sequence at its end.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// LOAD  | table entry for note_idx available; tone held off for one clk
// PLAY  | tone on, remaining counts down on sample_tick
// DONE  | one-cycle done pulse, then back to IDLE
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int PHASE_PRECISION = DEF_PHASE_PRECISION,
    parameter int DEPTH_LOG2      = DEF_DEPTH_LOG2,
    parameter int DUR_W           = DEF_DUR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic                       start,
    input  logic                       stop,
    input  logic [DEPTH_LOG2:0]        num_notes,
    input  logic                       loop,
    input  logic                       wr_en,
    input  logic [DEPTH_LOG2-1:0]      wr_addr,
    input  logic [PHASE_PRECISION-1:0] wr_inc,
    input  logic [DUR_W-1:0]           wr_dur,
    output logic [PHASE_PRECISION-1:0] phase_inc,
    output logic                       tone_en,
    output logic [DEPTH_LOG2-1:0]      note_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] MAX_NOTES = CNT_W'(2**DEPTH_LOG2);

    state_t                       state, state_nxt;
    logic [DEPTH_LOG2-1:0]        idx_nxt;
    logic [CNT_W-1:0]             notes_q, notes_nxt;
    logic [DUR_W-1:0]             remaining, remaining_nxt;
    logic [PHASE_PRECISION-1:0]   inc_nxt;
    logic                         tone_nxt, done_nxt;
    logic [PHASE_PRECISION+DUR_W-1:0] rd_data;
    logic [PHASE_PRECISION-1:0]   rd_inc;
    logic [DUR_W-1:0]             rd_dur;
    logic                         last_note, wrap;

    // Read address follows the next index so the entry is ready during LOAD.
    tone_seq_note_table #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (PHASE_PRECISION + DUR_W)
    ) u_table (
        .clk     (clk),
        .wr_en   (wr_en && !reset),
        .wr_addr (wr_addr),
        .wr_data ({wr_inc, wr_dur}),
        .rd_addr (idx_nxt),
        .rd_data (rd_data)
    );

    assign {rd_inc, rd_dur} = rd_data;
    assign last_note = (CNT_W'(note_idx) + CNT_W'(1)) >= notes_q;

`ifdef TONE_SEQ_LOOP_EN
    assign wrap = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign wrap = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        idx_nxt       = note_idx;
        notes_nxt     = notes_q;
        remaining_nxt = remaining;
        inc_nxt       = phase_inc;
        tone_nxt      = tone_en;
        done_nxt      = 1'b0;
        if (stop) begin
            state_nxt     = S_IDLE;
            idx_nxt       = '0;
            remaining_nxt = '0;
            inc_nxt       = '0;
            tone_nxt      = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_notes == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = S_LOAD;
                            idx_nxt   = '0;
                            notes_nxt = (num_notes > MAX_NOTES) ? MAX_NOTES : num_notes;
                        end
                    end
                end
                S_LOAD: begin
                    state_nxt     = S_PLAY;
                    inc_nxt       = rd_inc;
                    tone_nxt      = 1'b1;
                    remaining_nxt = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                end
                S_PLAY: begin
                    if (sample_tick) begin
                        if (remaining == DUR_W'(1)) begin
                            remaining_nxt = '0;
                            tone_nxt      = 1'b0;
                            if (!last_note) begin
                                idx_nxt   = note_idx + 1'b1;
                                state_nxt = S_LOAD;
                            end else if (wrap) begin
                                idx_nxt   = '0;
                                state_nxt = S_LOAD;
                            end else begin
                                state_nxt = S_DONE;
                                inc_nxt   = '0;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            remaining_nxt = remaining - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                    inc_nxt   = '0;
                    tone_nxt  = 1'b0;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            note_idx  <= '0;
            notes_q   <= '0;
            remaining <= '0;
            phase_inc <= '0;
            tone_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            note_idx  <= idx_nxt;
            notes_q   <= notes_nxt;
            remaining <= remaining_nxt;
            phase_inc <= inc_nxt;
            tone_en   <= tone_nxt;
            busy      <= (state_nxt != S_IDLE);
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: a monitor turns each tone_en burst
// into a (inc, ticks, idx) record that tasks compare against expected notes.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [4:0]  num_notes = '0;
    logic        loop = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_inc = '0;
    logic [15:0] wr_dur = '0;
    logic [15:0] phase_inc;
    logic        tone_en;
    logic [3:0]  note_idx;
    logic        busy;
    logic        done;

    tone_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .start       (start),
        .stop        (stop),
        .num_notes   (num_notes),
        .loop        (loop),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_inc      (wr_inc),
        .wr_dur      (wr_dur),
        .phase_inc   (phase_inc),
        .tone_en     (tone_en),
        .note_idx    (note_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inc;
        logic [31:0] ticks;
        logic [31:0] idx;
    } seg_t;

    seg_t exp_q[$];
    seg_t obs_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    bit   tick_en = 1'b0;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                sample_tick = (cnt == 3);
                cnt = (cnt + 1) % 4;
            end else begin
                sample_tick = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        seg_t cur;
        bit   in_seg;
        in_seg = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (tone_en === 1'b1) begin
                if (!in_seg) begin
                    in_seg = 1'b1;
                    cur.inc = 32'(phase_inc);
                    cur.ticks = 0;
                    cur.idx = 32'(note_idx);
                end
                if (sample_tick) cur.ticks = cur.ticks + 1;
            end else if (in_seg) begin
                obs_q.push_back(cur);
                in_seg = 1'b0;
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_note(input int a, input int inc, input int dur);
        step();
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_inc = 16'(inc);
        wr_dur = 16'(dur);
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_exp(input int inc, input int ticks, input int idx);
        seg_t s;
        s.inc = 32'(inc);
        s.ticks = 32'(ticks);
        s.idx = 32'(idx);
        exp_q.push_back(s);
    endtask

    task automatic test_reset();
        repeat (3) step();
        @(negedge clk);
        checks++; if (phase_inc !== 16'd0) begin errors++; $display("FAIL reset_phase_inc: got %0d, expected 0", phase_inc); end
        checks++; if (tone_en !== 1'b0) begin errors++; $display("FAIL reset_tone_en: got %b, expected 0", tone_en); end
        checks++; if (note_idx !== 4'd0) begin errors++; $display("FAIL reset_note_idx: got %0d, expected 0", note_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        seg_t e, o;
        write_note(0, 601, 3);
        write_note(1, 1202, 2);
        num_notes = 5'd2;
        tick_en = 1'b1;
        d0 = done_cnt;
        push_exp(601, 3, 0);
        push_exp(1202, 2, 1);
        pulse_start();
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: busy still %b, expected 0", busy); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses, expected 1", done_cnt - d0); end
        checks++; if (phase_inc !== 16'd0) begin errors++; $display("FAIL basic_idle_inc: got %0d, expected 0", phase_inc); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_seg_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL basic_seg: got inc=%0d ticks=%0d idx=%0d, expected inc=%0d ticks=%0d idx=%0d", o.inc, o.ticks, o.idx, e.inc, e.ticks, e.idx); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_latency();
        int d0;
        tick_en = 1'b0;
        num_notes = 5'd2;
        d0 = done_cnt;
        step();
        start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_pre_busy: got %b, expected 0", busy); end
        step();
        start = 1'b0;
        @(negedge clk);
        checks++; if ({busy, tone_en} !== 2'b10) begin errors++; $display("FAIL lat_load: got busy,tone_en=%b, expected 10", {busy, tone_en}); end
        @(negedge clk);
        checks++; if (tone_en !== 1'b1 || phase_inc !== 16'd601) begin errors++; $display("FAIL lat_play: got tone_en=%b inc=%0d, expected 1 601", tone_en, phase_inc); end
        pulse_start();
        @(negedge clk);
        checks++; if (tone_en !== 1'b1 || note_idx !== 4'd0) begin errors++; $display("FAIL busy_start_ignored: got tone_en=%b idx=%0d, expected 1 0", tone_en, note_idx); end
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        @(negedge clk);
        checks++; if ({busy, tone_en, phase_inc} !== 18'd0) begin errors++; $display("FAIL stop_idle: got busy=%b tone_en=%b inc=%0d, expected 0 0 0", busy, tone_en, phase_inc); end
        step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_wins: got busy=%b, expected 0", busy); end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL stop_no_done: got %0d pulses, expected 0", done_cnt - d0); end
        obs_q.delete();
    endtask

    task automatic test_stop();
        bit ok;
        int d0;
        seg_t e, o;
        write_note(0, 500, 4);
        write_note(1, 600, 4);
        write_note(2, 700, 4);
        num_notes = 5'd3;
        tick_en = 1'b1;
        d0 = done_cnt;
        push_exp(500, 4, 0);
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tone_en === 1'b1 && note_idx === 4'd1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL stop_reach_note1: idx=%0d, expected 1", note_idx); end
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        @(negedge clk);
        checks++; if ({busy, tone_en, phase_inc} !== 18'd0) begin errors++; $display("FAIL stop_mid: got busy=%b tone_en=%b inc=%0d, expected 0 0 0", busy, tone_en, phase_inc); end
        repeat (10) @(negedge clk);
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL stop_mid_done: got %0d pulses, expected 0", done_cnt - d0); end
        if (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL stop_seg0: got inc=%0d ticks=%0d idx=%0d, expected inc=%0d ticks=%0d idx=%0d", o.inc, o.ticks, o.idx, e.inc, e.ticks, e.idx); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_empty_and_dur0();
        bit ok;
        bit seen_busy;
        int d0;
        seg_t e, o;
        tick_en = 1'b1;
        num_notes = 5'd0;
        pulse_start();
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b, expected 1", done); end
        seen_busy = busy;
        repeat (5) begin @(negedge clk); seen_busy |= busy; end
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b, expected 0", seen_busy); end
        write_note(0, 777, 0);
        num_notes = 5'd1;
        d0 = done_cnt;
        push_exp(777, 1, 0);
        pulse_start();
        wait_idle(200, ok);
        checks++; if (!ok || done_cnt - d0 !== 1) begin errors++; $display("FAIL dur0_done: got ok=%b pulses=%0d, expected 1 1", ok, done_cnt - d0); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL dur0_seg_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL dur0_seg: got inc=%0d ticks=%0d idx=%0d, expected inc=%0d ticks=%0d idx=%0d", o.inc, o.ticks, o.idx, e.inc, e.ticks, e.idx); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clamp();
        bit ok;
        int d0;
        seg_t e, o;
        for (int i = 0; i < 16; i++) begin
            write_note(i, 100 + 3 * i, 1);
            push_exp(100 + 3 * i, 1, i);
        end
        num_notes = 5'd20;
        tick_en = 1'b1;
        d0 = done_cnt;
        pulse_start();
        wait_idle(1000, ok);
        checks++; if (!ok || done_cnt - d0 !== 1) begin errors++; $display("FAIL clamp_done: got ok=%b pulses=%0d, expected 1 1", ok, done_cnt - d0); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clamp_seg_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL clamp_seg: got inc=%0d ticks=%0d idx=%0d, expected inc=%0d ticks=%0d idx=%0d", o.inc, o.ticks, o.idx, e.inc, e.ticks, e.idx); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_write_during_play();
        bit ok;
        seg_t e, o;
        write_note(0, 100, 2);
        num_notes = 5'd1;
        tick_en = 1'b1;
        push_exp(100, 2, 0);
        push_exp(200, 3, 0);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        write_note(0, 200, 3);
        wait_idle(200, ok);
        pulse_start();
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_play_timeout: busy=%b, expected 0", busy); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wr_play_seg_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL wr_play_seg: got inc=%0d ticks=%0d idx=%0d, expected inc=%0d ticks=%0d idx=%0d", o.inc, o.ticks, o.idx, e.inc, e.ticks, e.idx); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_loop();
        bit ok;
        int d0;
        seg_t e, o;
        write_note(0, 300, 1);
        write_note(1, 400, 1);
        num_notes = 5'd2;
        tick_en = 1'b1;
        loop = 1'b1;
        d0 = done_cnt;
        pulse_start();
`ifdef TONE_SEQ_LOOP_EN
        push_exp(300, 1, 0);
        push_exp(400, 1, 1);
        push_exp(300, 1, 0);
        push_exp(400, 1, 1);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (obs_q.size() >= 3) begin ok = 1'b1; break; end
        end
        loop = 1'b0;
        checks++; if (!ok || done_cnt !== d0) begin errors++; $display("FAIL loop_wrap: got ok=%b pulses=%0d, expected 1 0", ok, done_cnt - d0); end
`else
        push_exp(300, 1, 0);
        push_exp(400, 1, 1);
`endif
        wait_idle(400, ok);
        loop = 1'b0;
        checks++; if (!ok || done_cnt - d0 !== 1) begin errors++; $display("FAIL loop_done: got ok=%b pulses=%0d, expected 1 1", ok, done_cnt - d0); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL loop_seg_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL loop_seg: got inc=%0d ticks=%0d idx=%0d, expected inc=%0d ticks=%0d idx=%0d", o.inc, o.ticks, o.idx, e.inc, e.ticks, e.idx); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_play();
        bit ok;
        seg_t e, o;
        write_note(0, 601, 3);
        write_note(1, 1202, 2);
        num_notes = 5'd2;
        tick_en = 1'b1;
        pulse_start();
        repeat (6) @(negedge clk);
        step();
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++; if ({busy, tone_en, done, note_idx, phase_inc} !== 23'd0) begin errors++; $display("FAIL reset_mid: got busy=%b tone_en=%b done=%b idx=%0d inc=%0d, expected all 0", busy, tone_en, done, note_idx, phase_inc); end
        repeat (2) @(negedge clk);
        exp_q.delete(); obs_q.delete();
        push_exp(601, 3, 0);
        push_exp(1202, 2, 1);
        pulse_start();
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_replay_timeout: busy=%b, expected 0", busy); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_replay_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_replay_seg: got inc=%0d ticks=%0d idx=%0d, expected inc=%0d ticks=%0d idx=%0d", o.inc, o.ticks, o.idx, e.inc, e.ticks, e.idx); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_stop();
        test_empty_and_dur0();
        test_clamp();
        test_write_during_play();
        test_loop();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter PHASE_PRECISION, default 16, width of the phase increment driven to the sine NCO.
REQ-002 Parameter DEPTH_LOG2, default 4, log2 of note-table entries (16 entries).
REQ-003 Parameter DUR_W, default 16, width of a note duration counted in sample ticks.
REQ-004 Clock and reset: one clock `clk`; reset is synchronous and active-high, named `reset`.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 sample_tick  input  1  one-cycle strobe at the audio sample rate (48 kHz).
REQ-008 start  input  1  pulse; begins playback at entry 0.
REQ-009 stop  input  1  pulse; aborts playback.
REQ-010 num_notes  input  DEPTH_LOG2+1  number of valid entries (0..16).
REQ-011 loop  input  1  repeat sequence after last note (only with TONE_SEQ_LOOP_EN).
REQ-012 wr_en / wr_addr / wr_inc / wr_dur  input  1 / DEPTH_LOG2 / PHASE_PRECISION / DUR_W  note-table write port.
REQ-013 phase_inc  output  PHASE_PRECISION  increment for the NCO phase accumulator.
REQ-014 tone_en  output  1  enable for the NCO; high only while a note plays.
REQ-015 note_idx  output  DEPTH_LOG2  index of current entry.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-018 FSM states IDLE, LOAD, PLAY, DONE; all outputs registered.
REQ-019 IDLE: start with num_notes!=0 -> LOAD, note_idx=0; start with num_notes==0 -> done pulses next cycle, FSM stays IDLE.
REQ-020 LOAD (exactly one cycle): table[note_idx] read; -> PLAY with phase_inc=entry inc, remaining=entry dur (dur 0 treated as 1).
REQ-021 Latency: start sampled at cycle N -> LOAD at N+1 -> tone_en=1 and phase_inc valid at N+2.
REQ-022 PLAY: each sample_tick decrements remaining; cycles without sample_tick hold remaining.
REQ-023 PLAY, sample_tick with remaining==1: if note_idx<num_notes-1 -> note_idx+1, LOAD; else -> DONE (or loop per REQ-031).
REQ-024 tone_en=0 during LOAD, so each note boundary inserts one clk of silence-hold (NCO phase frozen, not reset).
REQ-025 DONE: done=1 one cycle, -> IDLE; phase_inc=0, tone_en=0 in IDLE.
REQ-026 stop in any state: next cycle IDLE, tone_en=0, phase_inc=0, busy=0; done not asserted; stop wins over simultaneous start.
REQ-027 start while busy ignored.
REQ-028 Table writes accepted in any state; write to the entry being played takes effect only at that entry's next LOAD; write and read of same address in LOAD returns old data.
REQ-029 num_notes >16 clamps to 16; num_notes sampled only at start (held internally).

Reset
REQ-030 reset: state=IDLE, phase_inc=0, tone_en=0, note_idx=0, busy=0, done=0, remaining=0; table contents not cleared; reset overrides start/stop/wr_en.

Configuration
REQ-031 Macro TONE_SEQ_LOOP_EN defined: last note expiry with loop=1 -> note_idx=0, LOAD, no done pulse; loop sampled at each wrap.
REQ-032 TONE_SEQ_LOOP_EN undefined: loop input ignored, last note always -> DONE.

Structure
REQ-033 Package tone_seq_pkg holds state enum, note entry struct (inc, dur), default width constants.
REQ-034 Sub-module tone_seq_note_table: 2^DEPTH_LOG2 x (PHASE_PRECISION+DUR_W) RAM, one write port, one registered read port.

Verification
REQ-035 Table {0:inc=601,dur=3; 1:inc=1202,dur=2}, num_notes=2, start, tick every 4 clk -> phase_inc 601 for 3 ticks, 1202 for 2 ticks, done one pulse, busy then 0.
REQ-036 start at cycle 10 -> LOAD at 11, tone_en=1 at 12; start again at cycle 14 -> ignored.
REQ-037 stop during note 1 of a 3-note sequence -> next cycle IDLE, phase_inc=0, no done.
REQ-038 num_notes=0, start -> done pulse next cycle, busy never 1; entry dur=0 -> plays exactly 1 tick.
REQ-039 TONE_SEQ_LOOP_EN defined, loop=1, 2 notes -> note_idx 0,1,0,1 with no done; deassert loop -> done after next note 1.
REQ-040 reset asserted mid-PLAY together with start -> IDLE, all outputs 0; previously written table entries replay unchanged on next start.
